mine_placer: RTL and testbench
==============================

// Module: mine_placer
// PURPOSE
//  Parametrised mine-field generator for the Saper game; supersedes the fixed easy/medium/hard mine arrays.
//  On a start request it clears an NxN board (N = dim, run-time selectable up to MAX_DIM) and places
//  exactly mines_req mines at pseudo-random, non-duplicate cells. It then holds the map for the game logic.
//  Sits between the menu/settings FSM (dim, mines_req, start) and the board draw/click logic (map, rd port).
// PARAMETERS
//  MAX_DIM   16      largest board side; CW = $clog2(MAX_DIM) coordinate bits
//  MINES_W   9       width of mine count (up to 511)
//  LFSR_SEED 16'hACE1 reset/default seed; a zero seed is replaced by this value
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  reset, synchronous, active-high
//  seed_load  in   1                  load seed into LFSR this cycle
//  seed       in   16                 LFSR seed
//  start      in   1                  start generation; honoured in IDLE only
//  dim        in   CW+1               board side N, 2..MAX_DIM
//  mines_req  in   MINES_W            mines to place
//  busy       out  1                  CLEAR or PLACE in progress
//  done       out  1                  one-cycle pulse when placement completes
//  err        out  1                  sticky until next accepted start: request infeasible
//  mine_map   out  MAX_DIM*MAX_DIM    bit (y*MAX_DIM+x) = 1 -> mine; cells outside NxN always 0
//  mine_cnt   out  MINES_W            mines placed so far
//  rd_x,rd_y  in   CW                 query coordinate
//  rd_mine    out  1                  combinational mine_map bit at (rd_x,rd_y); 0 if outside NxN
// BEHAVIOUR
//  Reset: state IDLE, mine_map 0, mine_cnt 0, busy 0, done 0, err 0, LFSR = LFSR_SEED. Reset mid-run aborts and clears all.
//  LFSR: 16-bit Galois, taps 16'hB400, steps every cycle in every state (free-running entropy).
//  LFSR seed_load: loads seed (0 -> LFSR_SEED) and has priority over stepping.
//  FSM IDLE -> CLEAR -> PLACE -> IDLE.
//  IDLE: start=1 with dim, mines_req latched; err cleared.
//  IDLE feasibility check: if dim<2, dim>MAX_DIM or mines_req > capacity -> err=1, done pulse next cycle, stay IDLE.
//  IDLE: otherwise go to CLEAR. busy=1 from the cycle after start.
//  CLEAR: zero one row per cycle, y = 0..MAX_DIM-1 (MAX_DIM cycles); mine_cnt=0.
//  CLEAR: if mines_req==0 go straight to done, else go to PLACE.
//  PLACE, candidate: x = lfsr[CW-1:0], y = lfsr[2*CW-1:CW].
//  PLACE rejection: rejected (no write) if x>=dim, y>=dim, cell already set, or cell excluded.
//  PLACE accept: set bit, mine_cnt+1.
//  PLACE exit: when mine_cnt+1 == mines_req on an accepted cycle: busy 0, done=1 next cycle, -> IDLE.
//  start while busy is ignored; dim/mines_req changes after acceptance have no effect.
//  capacity = dim*dim (computed in 2*CW+2 bits, compared zero-extended); exact-capacity requests must complete.
//  Rejection sampling only; no watchdog. Completion is guaranteed by the maximal-length LFSR visiting all nonzero states.
// CONFIGURATION
//  SAFE_FIRST_CLICK_EN defined:
//   - ports safe_x, safe_y (in, CW) are added and latched at start.
//   - The 3x3 neighbourhood around (safe_x,safe_y), clipped to the board, is never mined.
//   - capacity = dim*dim - 9 (conservative even at edges/corners).
//  SAFE_FIRST_CLICK_EN undefined: no safe ports, no exclusion, capacity = dim*dim.
// STRUCTURE
//  Package saper_pkg holds:
//   - EASY_DIM=8, MEDIUM_DIM=10, HARD_DIM=16
//   - default mine counts
//   - typedef enum {IDLE,CLEAR,PLACE} placer_state_t
//   - LFSR_TAPS
//  Sub-module lfsr16: clk, rst, load, seed, q; a zero seed is replaced by LFSR_SEED.
//  Placer FSM, row-clear, feasibility and exclusion logic stay in mine_placer.
// TESTING
//  1. dim=8, mines_req=10, seed=16'h1234 -> done within 1000 cycles;
//     popcount(mine_map)=10, mine_cnt=10, no bit with x>=8 or y>=8.
//  2. dim=10, mines_req=100 (full board, macro off) -> done; all 100 in-board bits 1, out-of-board bits 0.
//  3. dim=8, mines_req=65 -> err=1 and one done pulse 2 cycles after start; mine_map unchanged, busy never 1.
//  4. Same seed, dim=16, mines_req=40 run twice -> identical mine_map;
//     start pulsed during busy -> ignored, no extra done.
//  5. rst asserted mid-PLACE -> next cycle mine_map=0, mine_cnt=0, busy=0; a following start completes normally.
//  6. SAFE_FIRST_CLICK_EN, dim=8, safe=(0,0), mines_req=55 -> done; (0..1,0..1) clear, popcount=55;
//     mines_req=56 -> err.

Source files
------------

// File: rtl/saper_pkg.sv
// Shared constants and types for the Saper mine-field generator: board presets,
// default mine counts, LFSR feedback taps and the placer state encoding.
package saper_pkg;

  localparam int EASY_DIM     = 8;
  localparam int MEDIUM_DIM   = 10;
  localparam int HARD_DIM     = 16;

  localparam int EASY_MINES   = 10;
  localparam int MEDIUM_MINES = 15;
  localparam int HARD_MINES   = 40;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2
  } placer_state_t;

  // One right-shift step of the Galois LFSR; the taps are folded in when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mine_placer_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the mine placer's entropy source.
// A zero seed would lock the register at zero, so it is replaced by SEED.
module lfsr16
  import saper_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
    if (load) begin
      state_d = (seed == 16'h0000) ? SEED : seed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/mine_placer.sv
// Mine-field generator: clears an NxN board row by row, then rejection-samples LFSR
// coordinates until the requested number of mines is placed. Optional macro
// SAFE_FIRST_CLICK_EN adds safe_x/safe_y and keeps their 3x3 neighbourhood mine-free.
module mine_placer
  import saper_pkg::*;
#(
  parameter int          MAX_DIM   = 16,
  parameter int          MINES_W   = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CW        = $clog2(MAX_DIM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed_load,
  input  logic [15:0]                  seed,
  input  logic                         start,
  input  logic [CW:0]                  dim,
  input  logic [MINES_W-1:0]           mines_req,
`ifdef SAFE_FIRST_CLICK_EN
  input  logic [CW-1:0]                safe_x,
  input  logic [CW-1:0]                safe_y,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [MAX_DIM*MAX_DIM-1:0]   mine_map,
  output logic [MINES_W-1:0]           mine_cnt,
  input  logic [CW-1:0]                rd_x,
  input  logic [CW-1:0]                rd_y,
  output logic                         rd_mine
);

  localparam int NCELL = MAX_DIM * MAX_DIM;
  localparam int IDXW  = $clog2(NCELL);
  localparam int SQW   = 2 * CW + 2;
  localparam int CMPW  = (SQW > MINES_W) ? SQW : MINES_W;

  placer_state_t        state_q, state_d;
  logic [CW-1:0]        row_q, row_d;
  logic [CW:0]          dim_q, dim_d;
  logic [MINES_W-1:0]   mines_q, mines_d;
  logic [MINES_W-1:0]   cnt_q, cnt_d;
  logic [NCELL-1:0]     map_q, map_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 pend_q, pend_d;

  logic [2*CW-1:0]      cand_bits;
  logic [15-2*CW:0]     lfsr_unused;
  logic [CW-1:0]        cand_x, cand_y;
  logic [IDXW-1:0]      cand_idx, rd_idx;
  logic                 cand_in_board, cand_excluded, cand_accept;

  logic [SQW-1:0]       dim_sq, capacity;
  logic                 dim_ok, req_ok, feasible;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .seed (seed),
    .q    ({lfsr_unused, cand_bits})
  );

  assign cand_x = cand_bits[CW-1:0];
  assign cand_y = cand_bits[2*CW-1:CW];

  // Capacity and the mine-count comparison share one zero-extended width so no bits are lost.
  assign dim_sq = SQW'(dim) * SQW'(dim);
`ifdef SAFE_FIRST_CLICK_EN
  assign capacity = (dim_sq > SQW'(9)) ? (dim_sq - SQW'(9)) : '0;
`else
  assign capacity = dim_sq;
`endif
  assign dim_ok   = (int'(dim) >= 2) && (int'(dim) <= MAX_DIM);
  assign req_ok   = CMPW'(mines_req) <= CMPW'(capacity);
  assign feasible = dim_ok && req_ok;

  assign cand_idx      = IDXW'(int'(cand_y) * MAX_DIM + int'(cand_x));
  assign cand_in_board = ({1'b0, cand_x} < dim_q) && ({1'b0, cand_y} < dim_q);

`ifdef SAFE_FIRST_CLICK_EN
  logic [CW-1:0] safe_x_q, safe_y_q;

  function automatic logic near(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] ae;
    logic [CW:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    return ((ae + (CW+1)'(1)) >= be) && (ae <= (be + (CW+1)'(1)));
  endfunction

  assign cand_excluded = near(cand_x, safe_x_q) && near(cand_y, safe_y_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      safe_x_q <= '0;
      safe_y_q <= '0;
    end else if (state_q == IDLE && start && feasible) begin
      safe_x_q <= safe_x;
      safe_y_q <= safe_y;
    end
  end
`else
  assign cand_excluded = 1'b0;
`endif

  assign cand_accept = cand_in_board && !map_q[cand_idx] && !cand_excluded;

  // Placer FSM: an infeasible request only raises err and a delayed done pulse,
  // otherwise the board is wiped one row per cycle before sampling begins.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dim_d   = dim_q;
    mines_d = mines_q;
    cnt_d   = cnt_q;
    map_d   = map_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pend_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        done_d = pend_q;
        if (start) begin
          err_d = 1'b0;
          if (!feasible) begin
            err_d  = 1'b1;
            pend_d = 1'b1;
          end else begin
            dim_d   = dim;
            mines_d = mines_req;
            cnt_d   = '0;
            row_d   = '0;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        map_d[int'(row_q)*MAX_DIM +: MAX_DIM] = '0;
        if (row_q == CW'(MAX_DIM - 1)) begin
          if (mines_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PLACE;
          end
        end else begin
          row_d = row_q + CW'(1);
        end
      end
      PLACE: begin
        if (cand_accept) begin
          map_d[cand_idx] = 1'b1;
          cnt_d           = cnt_q + MINES_W'(1);
          if ((cnt_q + MINES_W'(1)) == mines_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      dim_q   <= '0;
      mines_q <= '0;
      cnt_q   <= '0;
      map_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dim_q   <= dim_d;
      mines_q <= mines_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign rd_idx  = IDXW'(int'(rd_y) * MAX_DIM + int'(rd_x));
  assign rd_mine = ({1'b0, rd_x} < dim_q) && ({1'b0, rd_y} < dim_q) && map_q[rd_idx];

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign mine_map = map_q;
  assign mine_cnt = cnt_q;

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer: directed and randomized requests compared
// against a cell-array model of the placement rules.
module tb_mine_placer;

`ifdef SAFE_FIRST_CLICK_EN
  localparam bit SAFE = 1'b1;
`else
  localparam bit SAFE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         seed_load;
  logic [15:0]  seed;
  logic         start;
  logic [4:0]   dim;
  logic [8:0]   mines_req;
  logic [3:0]   safe_x, safe_y;
  logic         busy, done, err;
  logic [255:0] mine_map;
  logic [8:0]   mine_cnt;
  logic [3:0]   rd_x, rd_y;
  logic         rd_mine;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mine_placer dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .dim       (dim),
    .mines_req (mines_req),
`ifdef SAFE_FIRST_CLICK_EN
    .safe_x    (safe_x),
    .safe_y    (safe_y),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mine_map  (mine_map),
    .mine_cnt  (mine_cnt),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_mine   (rd_mine)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelStep(input int s);
    int r;
    r = s >> 1;
    if ((s & 1) != 0) r = r ^ 'hB400;
    return r;
  endfunction

  function automatic int modelCapacity(input int d);
    int c;
    c = d * d;
    if (SAFE) c = (c > 9) ? c - 9 : 0;
    return c;
  endfunction

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [255:0] boardMask(input int d);
    logic [255:0] m;
    m = '0;
    for (int y = 0; y < d; y++)
      for (int x = 0; x < d; x++)
        m[y*16+x] = 1'b1;
    return m;
  endfunction

  // Seed is loaded on the start edge; the board wipe takes 16 cycles, so the first
  // candidate comes from the seed advanced 16 times, then one candidate per cycle.
  task automatic modelRun(input int sd, input int d, input int m, input int sx, input int sy,
                          output logic [255:0] mp, output int placeCycles);
    int s, placed, x, y;
    s = (sd == 0) ? 'hACE1 : sd;
    repeat (16) s = modelStep(s);
    mp = '0;
    placed = 0;
    placeCycles = 0;
    while (placed < m && placeCycles < 70000) begin
      x = s & 15;
      y = (s >> 4) & 15;
      placeCycles++;
      if (x < d && y < d && !mp[y*16+x] &&
          !(SAFE && absDiff(x, sx) <= 1 && absDiff(y, sy) <= 1)) begin
        mp[y*16+x] = 1'b1;
        placed++;
      end
      s = modelStep(s);
    end
  endtask

  task automatic applyStimulus(input int sd, input int d, input int m, input int sx, input int sy,
                               input bit pokeStart, output logic [255:0] gotMap);
    logic [255:0] expMap;
    int n, k, rx, ry;
    bit seen, quiet;
    modelRun(sd, d, m, sx, sy, expMap, n);
    @(negedge clk);
    seed = 16'(sd); seed_load = 1'b1; start = 1'b1;
    dim = 5'(d); mines_req = 9'(m); safe_x = 4'(sx); safe_y = 4'(sy);
    @(posedge clk); #1;
    seed_load = 1'b0; start = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    k = 0;
    seen = 0;
    while (!seen && k < 16 + n + 50) begin
      @(posedge clk); #1;
      k++;
      if (pokeStart && k == 6) begin start = 1'b0; dim = 5'd3; mines_req = 9'd1; end
      if (pokeStart && k == 5) start = 1'b1;
      if (done) seen = 1;
    end
    start = 1'b0;
    checkOutput("doneSeen", seen, 1);
    checkOutput("doneLatency", k, 16 + n);
    checkOutput("busyAtDone", busy, 0);
    checkOutput("map", mine_map, expMap);
    checkOutput("mineCnt", mine_cnt, m);
    checkOutput("errClear", err, 0);
    repeat (4) begin
      rx = $urandom_range(0, 15);
      ry = $urandom_range(0, 15);
      rd_x = 4'(rx); rd_y = 4'(ry);
      #1;
      checkOutput("rdMine", rd_mine, (rx < d && ry < d) ? expMap[ry*16+rx] : 1'b0);
    end
    quiet = 1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 0;
    end
    checkOutput("singleDone", quiet, 1);
    gotMap = mine_map;
  endtask

  task automatic checkReject(input int d, input int m);
    logic [255:0] prevMap;
    prevMap = mine_map;
    @(negedge clk);
    start = 1'b1; dim = 5'(d); mines_req = 9'(m);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("rejErr", err, 1);
    checkOutput("rejDoneEarly", done, 0);
    checkOutput("rejBusy1", busy, 0);
    @(posedge clk); #1;
    checkOutput("rejDone", done, 1);
    checkOutput("rejBusy2", busy, 0);
    @(posedge clk); #1;
    checkOutput("rejDoneDrop", done, 0);
    checkOutput("rejMap", mine_map, prevMap);
    checkOutput("rejErrSticky", err, 1);
  endtask

  initial begin
    logic [255:0] mapA, mapB, full;
    int d, m, sx, sy, k;

    rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0;
    dim = '0; mines_req = '0; safe_x = '0; safe_y = '0; rd_x = '0; rd_y = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstMap", mine_map, 0);
    checkOutput("rstCnt", mine_cnt, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] easy board, 10 mines");
    applyStimulus('h1234, 8, 10, 3, 3, 0, mapA);
    checkOutput("easyPopcount", $countones(mapA), 10);
    checkOutput("easyOutside", mapA & ~boardMask(8), 0);

`ifndef SAFE_FIRST_CLICK_EN
    $display("[TB] full 10x10 board");
    applyStimulus('h1234, 10, 100, 0, 0, 0, mapA);
    full = boardMask(10);
    checkOutput("fullBoard", mapA, full);
`endif

    $display("[TB] infeasible requests");
    checkReject(8, 65);
    checkReject(1, 0);
    checkReject(17, 1);

    $display("[TB] repeatability with ignored start");
    applyStimulus('h5A5A, 16, 40, 7, 9, 0, mapA);
    applyStimulus('h5A5A, 16, 40, 7, 9, 1, mapB);
    checkOutput("sameSeedSameMap", mapB, mapA);

    $display("[TB] zero seed and zero mines");
    applyStimulus(0, 12, 20, 0, 11, 0, mapA);
    applyStimulus('hBEEF, 9, 0, 4, 4, 0, mapA);

    $display("[TB] reset mid-placement");
    @(negedge clk);
    seed = 16'h0F0F; seed_load = 1'b1; start = 1'b1; dim = 5'd16; mines_req = 9'd200;
    safe_x = 4'd8; safe_y = 4'd8;
    @(posedge clk); #1;
    seed_load = 1'b0; start = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("midRunBusy", busy, 1);
    checkOutput("midRunCnt", mine_cnt != 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortMap", mine_map, 0);
    checkOutput("abortCnt", mine_cnt, 0);
    checkOutput("abortBusy", busy, 0);
    rst = 1'b0;
    applyStimulus('h2468, 16, 30, 2, 13, 0, mapA);

    $display("[TB] randomized requests");
    repeat (6) begin
      d  = $urandom_range(2, 16);
      m  = modelCapacity(d) / 2;
      m  = $urandom_range(0, m);
      sx = $urandom_range(0, d - 1);
      sy = $urandom_range(0, d - 1);
      applyStimulus($urandom_range(0, 65535), d, m, sx, sy, 0, mapA);
    end

`ifdef SAFE_FIRST_CLICK_EN
    $display("[TB] safe first click");
    applyStimulus('h1234, 8, 55, 0, 0, 0, mapA);
    checkOutput("safeCorner", {mapA[17], mapA[16], mapA[1], mapA[0]}, 0);
    checkOutput("safePopcount", $countones(mapA), 55);
    checkReject(8, 56);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
